// File: rtl/ldpc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ldpc_pkg
//  Brief    : Shared LDPC decoder constants, loader state codes, LLR saturator.
//  Revision : 1.0
// ============================================================================
package ldpc_pkg;

    localparam int W     = 6;
    localparam int WIN   = 8;
    localparam int NB    = 16;
    localparam int LANES = 32;
    localparam int BEATS = 16;
    localparam int Z     = 511;
    localparam int BLKW  = 4;
    localparam int BEATW = 4;

    localparam int SAT_MAX = (1 << (W - 1)) - 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    // Symmetric clamp: the most negative W-bit code is never produced.
    function automatic logic [W-1:0] sat_llr(input logic [WIN-1:0] x);
        logic signed [WIN-1:0] sx;
        logic [W-1:0]          res;
        sx = $signed(x);
        if (sx > $signed(WIN'(SAT_MAX)))
            res = W'(SAT_MAX);
        else if (sx < $signed(WIN'(-SAT_MAX)))
            res = W'(-SAT_MAX);
        else
            res = x[W-1:0];
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ldpc_llr_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : ldpc_llr_loader_if
//  Brief    : Channel LLR word stream (valid/ready with start-of-frame flag).
//  Revision : 1.0
// ============================================================================
interface ldpc_llr_loader_if;
    import ldpc_pkg::*;

    logic [LANES*WIN-1:0] in_data;
    logic                 in_valid;
    logic                 in_sof;
    logic                 in_ready;

    modport master (output in_data, output in_valid, output in_sof, input  in_ready);
    modport slave  (input  in_data, input  in_valid, input  in_sof, output in_ready);

endinterface
`default_nettype wire

// File: rtl/llr_sat_lane.sv
`default_nettype none
// ============================================================================
//  Module   : llr_sat_lane
//  Brief    : Combinational WIN-bit to W-bit signed LLR saturator, one lane.
//  Revision : 1.0
// ============================================================================
module llr_sat_lane
    import ldpc_pkg::*;
(
    input  logic [WIN-1:0] llr_in,
    output logic [W-1:0]   llr_out
);

    assign llr_out = sat_llr(llr_in);

endmodule
`default_nettype wire

// File: rtl/ldpc_llr_loader.sv
`default_nettype none
// ============================================================================
//  Module   : ldpc_llr_loader
//  Brief    : Saturates channel LLR words and packs 16 blocks per Lmem beat.
//  Revision : 1.0
// ============================================================================
module ldpc_llr_loader
    import ldpc_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    ldpc_llr_loader_if.slave      in_if,
    input  logic                  dec_busy,
    output logic [NB*LANES*W-1:0] load_data,
    output logic                  loaden,
    output logic                  frame_loaded,
    output logic                  err_sync
);

    localparam logic [BLKW-1:0]  c_blk_last  = BLKW'(NB - 1);
    localparam logic [BEATW-1:0] c_beat_last = BEATW'(BEATS - 1);

    logic [1:0]                    r_state;
    logic [1:0]                    w_state_nxt;
    logic [BLKW-1:0]               r_blk;
    logic [BEATW-1:0]              r_beat;
    logic [NB-2:0][LANES*W-1:0]    r_asm;
    logic [NB*LANES*W-1:0]         r_load;
    logic                          r_loaden;
    logic                          r_frame_loaded;
    logic                          r_err_sync;
    logic                          w_loaden_nxt;
    logic                          w_frame_nxt;
    logic                          w_err_nxt;
    logic                          w_ready;
    logic                          w_accept;
    logic                          w_restart;
    logic                          w_store;
    logic                          w_pad;
    logic [LANES*W-1:0]            w_word;

    assign w_ready   = !rst && ((r_state == ST_IDLE && !dec_busy) || r_state == ST_COLLECT);
    assign w_accept  = in_if.in_valid && w_ready;
    assign w_restart = w_accept && in_if.in_sof;
    assign w_store   = w_accept && !in_if.in_sof && (r_state == ST_COLLECT);
    assign w_pad     = (r_state == ST_COLLECT) && !in_if.in_sof && (r_beat == c_beat_last);

    assign in_if.in_ready = w_ready;
    assign load_data      = r_load;
    assign loaden         = r_loaden;
    assign frame_loaded   = r_frame_loaded;
    assign err_sync       = r_err_sync;

    // Positions at or beyond Z in the last beat are padding and load as zero.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [W-1:0] w_sat;
        llr_sat_lane u_sat (
            .llr_in  (in_if.in_data[l*WIN +: WIN]),
            .llr_out (w_sat)
        );
        if ((BEATS - 1) * LANES + l >= Z) begin : g_pad
            assign w_word[l*W +: W] = w_pad ? '0 : w_sat;
        end else begin : g_pass
            assign w_word[l*W +: W] = w_sat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_restart) w_state_nxt = ST_COLLECT;
            ST_COLLECT: if (w_store && r_blk == c_blk_last && r_beat == c_beat_last)
                            w_state_nxt = ST_DONE;
            ST_DONE:    w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_loaden_nxt = 1'b0;
        w_frame_nxt  = 1'b0;
        w_err_nxt    = 1'b0;
        case (r_state)
            ST_IDLE:    w_err_nxt = w_accept && !in_if.in_sof;
            ST_COLLECT: begin
                w_err_nxt    = w_restart;
                w_loaden_nxt = w_store && (r_blk == c_blk_last);
            end
            ST_DONE:    w_frame_nxt = 1'b1;
            default:    ;
        endcase
    end

    // The last block of a beat goes straight to the output register, so the
    // assembly register only holds the first NB-1 blocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blk          <= '0;
            r_beat         <= '0;
            r_asm          <= '0;
            r_load         <= '0;
            r_loaden       <= 1'b0;
            r_frame_loaded <= 1'b0;
            r_err_sync     <= 1'b0;
        end else begin
            r_loaden       <= w_loaden_nxt;
            r_frame_loaded <= w_frame_nxt;
            r_err_sync     <= w_err_nxt;
            if (w_restart) begin
                r_asm[0] <= w_word;
                r_blk    <= BLKW'(1);
                r_beat   <= '0;
            end else if (w_store) begin
                r_blk <= r_blk + 1'b1;
                if (r_blk == c_blk_last) begin
                    r_beat <= r_beat + 1'b1;
                    r_load <= {w_word, r_asm};
                end else begin
                    r_asm[r_blk] <= w_word;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ldpc_llr_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ldpc_llr_loader
//  Brief    : Self-checking bench for the LLR loader (table + scoreboard).
//  Revision : 1.0
// ============================================================================
module tb_ldpc_llr_loader;
    import ldpc_pkg::*;

    localparam int DW = NB * LANES * W;

    typedef struct {
        int in_v;
        int exp_v;
    } sat_rec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          dec_busy = 1'b0;
    logic [DW-1:0] load_data;
    logic          loaden;
    logic          frame_loaded;
    logic          err_sync;

    ldpc_llr_loader_if in_if ();

    ldpc_llr_loader dut (
        .clk          (clk),
        .rst          (rst),
        .in_if        (in_if),
        .dec_busy     (dec_busy),
        .load_data    (load_data),
        .loaden       (loaden),
        .frame_loaded (frame_loaded),
        .err_sync     (err_sync)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            n_loaden = 0;
    int            n_frame = 0;
    int            n_err = 0;
    int            prev_loaden_cyc = -1;
    bit            chk_gap = 1'b0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mon_exp;
    sat_rec_t      sat_tab[BEATS];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic signed [63:0] act,
                                input logic signed [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic int sat_ref(input int v);
        if (v > 31)  return 31;
        if (v < -31) return -31;
        return v;
    endfunction

    function automatic int lane_val(input int pat, input int beat, input int blk, input int lane);
        if (pat == 0) return ((blk * 32 + lane + beat) % 64) - 32;
        return sat_tab[beat].in_v;
    endfunction

    function automatic logic [LANES*WIN-1:0] mk_word(input int pat, input int beat, input int blk);
        logic [LANES*WIN-1:0] w;
        for (int l = 0; l < LANES; l++) w[l*WIN +: WIN] = WIN'(lane_val(pat, beat, blk, l));
        return w;
    endfunction

    function automatic logic [DW-1:0] mk_beat(input int pat, input int beat);
        logic [DW-1:0] d;
        int v;
        for (int b = 0; b < NB; b++)
            for (int l = 0; l < LANES; l++) begin
                v = (beat == 15 && l == 31) ? 0 : sat_ref(lane_val(pat, beat, b, l));
                d[(b*LANES+l)*W +: W] = W'(v);
            end
        return d;
    endfunction

    function automatic int lane_of(input logic [DW-1:0] d, input int b, input int l);
        logic signed [W-1:0] s;
        s = d[(b*LANES+l)*W +: W];
        return int'(s);
    endfunction

    // Scoreboard side: every loaden pops one expected beat.
    always @(negedge clk) begin
        if (loaden === 1'b1) begin
            n_loaden++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL loaden_unexpected: loaden=1 with no completed group, required 0 (cycle %0d)", cyc);
            end else begin
                mon_exp = exp_q.pop_front();
                if (load_data !== mon_exp) begin
                    failures++;
                    for (int i = 0; i < NB*LANES; i++)
                        if (load_data[i*W +: W] !== mon_exp[i*W +: W]) begin
                            $display("FAIL beat_data: block %0d lane %0d got %0d required %0d (cycle %0d)",
                                     i / LANES, i % LANES, lane_of(load_data, i / LANES, i % LANES),
                                     lane_of(mon_exp, i / LANES, i % LANES), cyc);
                            break;
                        end
                end
            end
            if (chk_gap && prev_loaden_cyc >= 0) chk("loaden_gap", cyc - prev_loaden_cyc, 16);
            prev_loaden_cyc = cyc;
        end
        if (frame_loaded === 1'b1) begin
            n_frame++;
            chk("frame_after_last_loaden", cyc - prev_loaden_cyc, 1);
        end
        if (err_sync === 1'b1) n_err++;
    end

    task automatic send_word(input logic [LANES*WIN-1:0] d, input logic sof);
        int n = 0;
        in_if.in_data  = d;
        in_if.in_sof   = sof;
        in_if.in_valid = 1'b1;
        while (in_if.in_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready stayed low for %0d cycles, required 1", n);
        end
        @(posedge clk);
        #1;
        in_if.in_valid = 1'b0;
        in_if.in_sof   = 1'b0;
    endtask

    task automatic send_range(input int pat, input bit thr, input int first, input int last);
        int beat, blk, gap;
        for (int idx = first; idx <= last; idx++) begin
            beat = idx / NB;
            blk  = idx % NB;
            gap  = 0;
            while (thr && $urandom_range(0, 1) == 1 && gap < 8) begin
                @(posedge clk);
                #1;
                gap++;
            end
            if (blk == NB - 1) exp_q.push_back(mk_beat(pat, beat));
            send_word(mk_word(pat, beat, blk), idx == 0);
        end
    endtask

    task automatic wait_frame(input int target);
        int n = 0;
        while (n_frame < target && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("frame_loaded_count", n_frame, target);
    endtask

    initial begin
        int base, e0, rdy_hi;
        sat_tab = '{'{127, 31}, '{-128, -31}, '{31, 31}, '{-31, -31},
                    '{-32, -31}, '{0, 0}, '{1, 1}, '{-1, -1},
                    '{32, 31}, '{-33, -31}, '{100, 31}, '{-100, -31},
                    '{15, 15}, '{-16, -16}, '{30, 30}, '{-30, -30}};
        in_if.in_valid = 1'b0;
        in_if.in_sof   = 1'b0;
        in_if.in_data  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_if.in_ready, 0);
        chk("rst_loaden", loaden, 0);
        chk("rst_frame_loaded", frame_loaded, 0);
        chk("rst_err_sync", err_sync, 0);
        chk("rst_load_data_nonzero", |load_data, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", in_if.in_ready, 1);

        // Continuous frame: beats 16 cycles apart, frame_loaded right after
        base = n_loaden;
        prev_loaden_cyc = -1;
        chk_gap = 1'b1;
        send_range(0, 1'b0, 0, NB*BEATS-1);
        wait_frame(1);
        chk_gap = 1'b0;
        chk("cont_loaden_count", n_loaden - base, 16);

        // Saturation table: one table record per beat
        for (int k = 0; k < BEATS; k++) begin
            for (int b = 0; b < NB; b++) begin
                if (b == NB - 1) exp_q.push_back(mk_beat(1, k));
                send_word(mk_word(1, k, b), k == 0 && b == 0);
            end
            @(negedge clk);
            chk("sat_loaden_latency", loaden, 1);
            chk("sat_lane_b3_l5", lane_of(load_data, 3, 5), sat_tab[k].exp_v);
            chk("sat_lane_b15_l31", lane_of(load_data, 15, 31), (k == BEATS-1) ? 0 : sat_tab[k].exp_v);
        end
        wait_frame(2);

        // Throttled input
        base = n_loaden;
        send_range(0, 1'b1, 0, NB*BEATS-1);
        wait_frame(3);
        chk("thr_loaden_count", n_loaden - base, 16);

        // Word without sof in IDLE
        e0 = n_err;
        base = n_loaden;
        send_word(mk_word(0, 0, 5), 1'b0);
        repeat (3) @(negedge clk);
        chk("idle_nosof_err", n_err - e0, 1);
        chk("idle_nosof_loaden", n_loaden - base, 0);

        // sof arriving at beat 3, blk 7
        e0 = n_err;
        base = n_loaden;
        send_range(0, 1'b0, 0, 3*NB + 6);
        send_range(0, 1'b0, 0, NB*BEATS-1);
        wait_frame(4);
        chk("midframe_sof_err", n_err - e0, 1);
        chk("midframe_loaden_count", n_loaden - base, 19);

        // dec_busy in IDLE blocks; rising during COLLECT is ignored
        e0 = n_err;
        base = n_loaden;
        rdy_hi = 0;
        dec_busy = 1'b1;
        in_if.in_data  = mk_word(0, 0, 0);
        in_if.in_sof   = 1'b1;
        in_if.in_valid = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (in_if.in_ready !== 1'b0) rdy_hi++;
        end
        chk("busy_ready_cycles", rdy_hi, 0);
        chk("busy_no_loaden", n_loaden - base, 0);
        chk("busy_no_err", n_err - e0, 0);
        dec_busy = 1'b0;
        fork
            begin
                repeat (40) @(posedge clk);
                #1 dec_busy = 1'b1;
            end
        join_none
        send_range(0, 1'b0, 0, NB*BEATS-1);
        wait_frame(5);
        chk("busy_frame_loaden_count", n_loaden - base, 16);
        chk("busy_idle_ready_low", in_if.in_ready, 0);
        dec_busy = 1'b0;

        // Reset at beat 8
        send_range(0, 1'b0, 0, 8*NB + 3);
        @(negedge clk);
        chk("pre_rst_pending_beats", exp_q.size(), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", in_if.in_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_loaden", loaden, 0);
        chk("post_rst_load_data_nonzero", |load_data, 0);
        chk("post_rst_frame_loaded", frame_loaded, 0);
        chk("post_rst_err_sync", err_sync, 0);
        base = n_loaden;
        send_range(0, 1'b0, 0, NB*BEATS-1);
        wait_frame(6);
        chk("post_rst_loaden_count", n_loaden - base, 16);

        repeat (3) @(negedge clk);
        chk("final_pending_beats", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
